// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, opcode-specific execute T3-T7, then back to T0.
// Optional macro ILLEGAL_OP_TRAP_EN traps unlisted opcodes into HALT with illegal=1.
module control_sequencer #(
    parameter logic [4:0] ALU_ADD   = 5'd3,
    parameter logic [4:0] ALU_INCPC = 5'd14
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        run,
    output logic        illegal
);

    localparam int unsigned EnY = 17, EnZ = 18, EnPc = 20, EnMdr = 21, EnIr = 24;
    localparam int unsigned EnMar = 25, EnOutPort = 26, EnCon = 27;
    localparam int unsigned BsReg = 0, BsZlo = 19, BsPc = 20, BsMdr = 21, BsC = 22, BsIn = 23;

    localparam logic [4:0] OpLd = 5'b00000, OpLdi = 5'b00001, OpSt = 5'b00010;
    localparam logic [4:0] OpAdd = 5'b00011, OpSub = 5'b00100, OpAnd = 5'b00101;
    localparam logic [4:0] OpOr = 5'b00110, OpAddi = 5'b01100, OpAndi = 5'b01101;
    localparam logic [4:0] OpOri = 5'b01110, OpBr = 5'b10010, OpIn = 5'b10110;
    localparam logic [4:0] OpOut = 5'b10111, OpNop = 5'b11010, OpHalt = 5'b11011;

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    state_e state_q, state_d;

    logic [4:0] op;
    logic       unused_ir;
    logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_in, is_out, is_legal;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];

    assign is_alu   = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr);
    assign is_imm   = (op == OpAddi) || (op == OpAndi) || (op == OpOri);
    assign is_ldi   = (op == OpLdi);
    assign is_ld    = (op == OpLd);
    assign is_st    = (op == OpSt);
    assign is_br    = (op == OpBr);
    assign is_in    = (op == OpIn);
    assign is_out   = (op == OpOut);
    // Opcodes that own an execute sequence starting at T3
    assign is_legal = is_alu || is_imm || is_ldi || is_ld || is_st || is_br || is_in || is_out;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = StT2;
            StT2: begin
                if (op == OpNop)      state_d = StT0;
                else if (op == OpHalt) state_d = StHalt;
                else if (is_legal)    state_d = StT3;
                else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StT0;
`endif
                end
            end
            StT3:    state_d = (is_in || is_out || !is_legal) ? StT0 : StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = (is_ld || is_st || is_br) ? StT6 : StT0;
            StT6:    state_d = (is_ld || is_st) ? StT7 : StT0;
            StT7:    state_d = StT0;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StReset;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StT2 && !is_legal && op != OpNop && op != OpHalt) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign illegal = illegal_q;
`else
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= StReset;
        else      state_q <= state_d;
    end

    assign illegal = 1'b0;
`endif

    assign run = (state_q != StHalt);

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Control_Signals = '0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        case (state_q)
            StT0: begin
                busSelect[BsPc] = 1'b1;
                enable[EnMar]   = 1'b1;
                enable[EnZ]     = 1'b1;
                Control_Signals = ALU_INCPC;
            end
            StT1: begin
                busSelect[BsZlo] = 1'b1;
                enable[EnPc]     = 1'b1;
                enable[EnMdr]    = 1'b1;
                MD_Read          = 1'b1;
                ReadRAM          = 1'b1;
            end
            StT2: begin
                busSelect[BsMdr] = 1'b1;
                enable[EnIr]     = 1'b1;
            end
            StT3: begin
                if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; enable[EnY] = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; enable[EnY] = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; enable[EnCon] = 1'b1;
                end else if (is_in) begin
                    busSelect[BsIn] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_out) begin
                    Gra = 1'b1; Rout = 1'b1; enable[EnOutPort] = 1'b1;
                end
            end
            StT4: begin
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Control_Signals = op; enable[EnZ] = 1'b1;
                end else if (is_imm) begin
                    busSelect[BsC] = 1'b1;
                    enable[EnZ]    = 1'b1;
                    // Immediate forms reuse the ALU codes of their register counterparts
                    case (op)
                        OpAndi:  Control_Signals = OpAnd;
                        OpOri:   Control_Signals = OpOr;
                        default: Control_Signals = ALU_ADD;
                    endcase
                end else if (is_ldi || is_ld || is_st) begin
                    busSelect[BsC] = 1'b1; Control_Signals = ALU_ADD; enable[EnZ] = 1'b1;
                end else if (is_br) begin
                    busSelect[BsPc] = 1'b1; enable[EnY] = 1'b1;
                end
            end
            StT5: begin
                if (is_alu || is_imm || is_ldi) begin
                    busSelect[BsZlo] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    busSelect[BsZlo] = 1'b1; enable[EnMar] = 1'b1;
                end else if (is_br) begin
                    busSelect[BsC] = 1'b1; Control_Signals = ALU_ADD; enable[EnZ] = 1'b1;
                end
            end
            StT6: begin
                if (is_ld) begin
                    MD_Read = 1'b1; ReadRAM = 1'b1; enable[EnMdr] = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; enable[EnMdr] = 1'b1;
                end else if (is_br) begin
                    busSelect[BsZlo] = 1'b1; enable[EnPc] = con_ff;
                end
            end
            StT7: begin
                if (is_ld) begin
                    busSelect[BsMdr] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    WriteRAM = 1'b1;
                end
            end
            default: ;
        endcase
        if (Rout || BAout) busSelect[BsReg] = 1'b1;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: checks every output, cycle by cycle, against
// hand-derived vectors; compile with ILLEGAL_OP_TRAP_EN to check the trap variant.
module tb_control_sequencer;

    localparam logic [31:0] E_Y = 32'h0002_0000, E_Z = 32'h0004_0000, E_PC = 32'h0010_0000;
    localparam logic [31:0] E_MDR = 32'h0020_0000, E_IR = 32'h0100_0000;
    localparam logic [31:0] E_MAR = 32'h0200_0000, E_OUT = 32'h0400_0000;
    localparam logic [31:0] E_CON = 32'h0800_0000;
    localparam logic [31:0] B_REG = 32'h0000_0001, B_ZLO = 32'h0008_0000;
    localparam logic [31:0] B_PC = 32'h0010_0000, B_MDR = 32'h0020_0000;
    localparam logic [31:0] B_C = 32'h0040_0000, B_IN = 32'h0080_0000;
    localparam logic [10:0] S_MDRD = 11'h400, S_RRAM = 11'h200, S_WRAM = 11'h100;
    localparam logic [10:0] S_GRA = 11'h080, S_GRB = 11'h040, S_GRC = 11'h020;
    localparam logic [10:0] S_RIN = 11'h010, S_ROUT = 11'h008, S_BA = 11'h004;
    localparam logic [10:0] S_RUN = 11'h002, S_ILL = 11'h001;

    logic        clk, clr, con_ff;
    logic [31:0] ir, enable, busSelect;
    logic [4:0]  Control_Signals;
    logic        MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal;
    logic [10:0] strb;

    int total = 0;
    int bad   = 0;

    control_sequencer dut (
        .clk            (clk),
        .clr            (clr),
        .ir             (ir),
        .con_ff         (con_ff),
        .enable         (enable),
        .busSelect      (busSelect),
        .Control_Signals(Control_Signals),
        .MD_Read        (MD_Read),
        .ReadRAM        (ReadRAM),
        .WriteRAM       (WriteRAM),
        .Gra            (Gra),
        .Grb            (Grb),
        .Grc            (Grc),
        .Rin            (Rin),
        .Rout           (Rout),
        .BAout          (BAout),
        .run            (run),
        .illegal        (illegal)
    );

    assign strb = {MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] en, input logic [31:0] bs,
                              input logic [4:0] cs, input logic [10:0] st);
        chk({tag, " enable"}, enable, en);
        chk({tag, " busSelect"}, busSelect, bs);
        chk({tag, " cs"}, {27'd0, Control_Signals}, {27'd0, cs});
        chk({tag, " strobes"}, {21'd0, strb}, {21'd0, st});
        chk({tag, " onehot0"}, 32'($onehot0(busSelect)), 32'd1);
    endtask

    // Checks T0..T2 and leaves the bench at the T3 sample point
    task automatic fetch(input string tag);
        expect_out({tag, " T0"}, E_MAR | E_Z, B_PC, 5'd14, S_RUN);
        step();
        expect_out({tag, " T1"}, E_PC | E_MDR, B_ZLO, 5'd0, S_MDRD | S_RRAM | S_RUN);
        step();
        expect_out({tag, " T2"}, E_IR, B_MDR, 5'd0, S_RUN);
        step();
    endtask

    task automatic mem_t3_t5(input string tag);
        expect_out({tag, " T3"}, E_Y, B_REG, 5'd0, S_GRB | S_BA | S_RUN);
        step();
        expect_out({tag, " T4"}, E_Z, B_C, 5'd3, S_RUN);
        step();
        expect_out({tag, " T5"}, E_MAR, B_ZLO, 5'd0, S_RUN);
        step();
    endtask

    task automatic branch(input string tag, input logic cond);
        con_ff = cond;
        ir = 32'h9000_0000;
        fetch(tag);
        expect_out({tag, " T3"}, E_CON, B_REG, 5'd0, S_GRA | S_ROUT | S_RUN);
        step();
        expect_out({tag, " T4"}, E_Y, B_PC, 5'd0, S_RUN);
        step();
        expect_out({tag, " T5"}, E_Z, B_C, 5'd3, S_RUN);
        step();
        expect_out({tag, " T6"}, cond ? E_PC : 32'd0, B_ZLO, 5'd0, S_RUN);
        step();
    endtask

    initial begin
        clr = 1'b0;
        ir = 32'd0;
        con_ff = 1'b0;
        step();
        step();
        expect_out("reset", 32'd0, 32'd0, 5'd0, S_RUN);
        clr = 1'b1;
        step();

        // add r2, r1, r1
        ir = 32'h1908_8000;
        fetch("add");
        expect_out("add T3", E_Y, B_REG, 5'd0, S_GRB | S_ROUT | S_RUN);
        step();
        expect_out("add T4", E_Z, B_REG, 5'd3, S_GRC | S_ROUT | S_RUN);
        step();
        expect_out("add T5", 32'd0, B_ZLO, 5'd0, S_GRA | S_RIN | S_RUN);
        step();

        // add again, then asynchronous reset in the middle of T4
        fetch("add2");
        step();
        expect_out("add2 T4", E_Z, B_REG, 5'd3, S_GRC | S_ROUT | S_RUN);
        clr = 1'b0;
        #1;
        expect_out("clr mid T4", 32'd0, 32'd0, 5'd0, S_RUN);
        #2;
        clr = 1'b1;
        step();

        // ld
        ir = 32'h0000_0000;
        fetch("ld");
        mem_t3_t5("ld");
        expect_out("ld T6", E_MDR, 32'd0, 5'd0, S_MDRD | S_RRAM | S_RUN);
        step();
        expect_out("ld T7", 32'd0, B_MDR, 5'd0, S_GRA | S_RIN | S_RUN);
        step();

        // st
        ir = 32'h1000_0000;
        fetch("st");
        mem_t3_t5("st");
        expect_out("st T6", E_MDR, B_REG, 5'd0, S_GRA | S_ROUT | S_RUN);
        step();
        expect_out("st T7", 32'd0, 32'd0, 5'd0, S_WRAM | S_RUN);
        step();

        branch("br taken", 1'b1);
        branch("br not", 1'b0);

        // ori: CS must be the OR code
        ir = 32'h7000_0000;
        fetch("ori");
        expect_out("ori T3", E_Y, B_REG, 5'd0, S_GRB | S_ROUT | S_RUN);
        step();
        expect_out("ori T4", E_Z, B_C, 5'd6, S_RUN);
        step();
        expect_out("ori T5", 32'd0, B_ZLO, 5'd0, S_GRA | S_RIN | S_RUN);
        step();

        ir = 32'hB000_0000;
        fetch("in");
        expect_out("in T3", 32'd0, B_IN, 5'd0, S_GRA | S_RIN | S_RUN);
        step();

        ir = 32'hB800_0000;
        fetch("out");
        expect_out("out T3", E_OUT, B_REG, 5'd0, S_GRA | S_ROUT | S_RUN);
        step();

        ir = 32'hD000_0000;
        fetch("nop");

        // unlisted opcode 11111
        ir = 32'hF800_0000;
        fetch("ill");
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            expect_out("ill trap", 32'd0, 32'd0, 5'd0, S_ILL);
            step();
        end
        clr = 1'b0;
        #1;
        expect_out("ill cleared", 32'd0, 32'd0, 5'd0, S_RUN);
        #2;
        clr = 1'b1;
        step();
`endif

        ir = 32'hD800_0000;
        fetch("halt");
        ir = 32'h1908_8000;
        for (int i = 0; i < 20; i++) begin
            expect_out("halt hold", 32'd0, 32'd0, 5'd0, 11'h000);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the Phase-2 datapath.
- Generates, cycle by cycle, the enable, busSelect, ALU-op, register-select and memory strobes that the datapath consumes.
- Runs fetch (T0-T2), then an opcode-specific execute sequence, then returns to T0.
- Instantiated beside the datapath; takes the datapath's ir and con_ff as inputs.

Parameters:
- ALU_ADD, 5'd3, ALU code for add / effective address.
- ALU_INCPC, 5'd14, ALU code for PC+1.

Ports:
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- ir  in  32  datapath IR output; opcode = ir[31:27]
- con_ff  in  1  branch-condition flop from datapath
- enable  out  32  register load enables
- busSelect  out  32  bus source selects, at most one bit high
- Control_Signals  out  5  ALU operation
- MD_Read, ReadRAM, WriteRAM  out  1 each  memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/strobes
- run  out  1  high while executing, low after halt
- illegal  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Bit map, fixed:
  - enable: Yin=17, Zin=18, PCin=20, MDRin=21, IRin=24, MARin=25, OutPortIn=26, CONin=27.
  - busSelect: RegOut=0 (asserted with Rout or BAout), Zlo=19, PC=20, MDR=21, Cout=22, InPort=23.
- Moore FSM. States RESET, T0..T7, HALT. Outputs are a combinational decode of state and ir[31:27]; every signal not listed for a state is 0.
- Reset:
  - clr low forces RESET immediately (async).
  - In RESET all outputs are 0, run=1, illegal=0.
  - First rising edge after clr returns high moves to T0.
  - Reset mid-sequence abandons that sequence with no partial writes after assertion.
- Fetch:
  - T0: busSelect20, enable25, enable18, CS=ALU_INCPC.
  - T1: busSelect19, enable20, enable21, MD_Read, ReadRAM.
  - T2: busSelect21, enable24.
- ir is valid from T3 onward. Execute states by opcode:
  - add 00011 / sub 00100 / and 00101 / or 00110:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, CS=opcode, Zin.
    - T5: busSelect19, Gra, Rin. Then T0.
  - addi 01100 / andi 01101 / ori 01110:
    - T3: Grb, Rout, Yin.
    - T4: Cout, CS=3/5/6 respectively, Zin.
    - T5: busSelect19, Gra, Rin.
  - ldi 00001:
    - T3: Grb, BAout, Yin.
    - T4: Cout, CS=ALU_ADD, Zin.
    - T5: busSelect19, Gra, Rin.
  - ld 00000:
    - T3-T4 as ldi.
    - T5: busSelect19, MARin.
    - T6: MD_Read, ReadRAM, MDRin.
    - T7: busSelect21, Gra, Rin.
  - st 00010:
    - T3-T5 as ld.
    - T6: Gra, Rout, MDRin (MD_Read=0).
    - T7: WriteRAM.
  - br 10010:
    - T3: Gra, Rout, CONin.
    - T4: busSelect20, Yin.
    - T5: Cout, CS=ALU_ADD, Zin.
    - T6: busSelect19, and PCin only if con_ff=1.
  - in 10110: T3: InPort, Gra, Rin.
  - out 10111: T3: Gra, Rout, OutPortIn.
  - nop 11010: T2 goes directly to T0.
  - halt 11011: T2 goes to HALT. HALT holds all outputs 0 and run=0 until reset.
- Total cycles per instruction:
  - nop: 3
  - in/out: 4
  - ALU/ldi: 6
  - br: 7
  - ld/st: 8
- ir changes after T2 are ignored except through the current-state decode; the datapath does not load IR outside T2.
- Simultaneous RegOut, PC, MDR or Zlo selects never occur; verification asserts one-hot-or-zero on busSelect.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined: any unlisted opcode goes T2 to HALT; illegal=1 and run=0 until reset.
- Undefined: unlisted opcodes behave as nop (T2 to T0); illegal tied 0.

Test Plan:
- clr=0 mid-T4 of an add -> all outputs 0 within the same cycle. After release: T0 on the next edge, busSelect=32'h0010_0000, CS=14.
- ir=32'h1908_8000 (add, ra=2, rb=1, rc=1) -> T3 Grb+Rout+enable17; T4 Grc+Rout+CS=3+enable18; T5 busSelect19+Gra+Rin; back to T0 after 6 cycles total.
- ld (opcode 00000) -> ReadRAM high only in T1 and T6; busSelect21 with Rin in T7; 8-cycle period.
- st -> WriteRAM high only in T7, with MD_Read=0 in T6.
- br with con_ff=1 -> enable20 high in T6. Same with con_ff=0 -> enable20 low in T6. Both cases: 7-cycle period.
- halt -> run=0 and outputs held 0 for 20 cycles. With opcode 11111: with ILLEGAL_OP_TRAP_EN, illegal=1 and HALT; without it, T0 after 3 cycles.
